// File: rtl/tick_sched_pkg.sv
//------------------------------------------------------------------------------
// tick_sched_pkg: shared types and constants for the tick burst scheduler.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package tick_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_DIV_W = 3;
    localparam int DEF_LEN_W = 8;
    localparam int STAT_W    = 16;

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
//------------------------------------------------------------------------------
// tick_prescaler: divide-by-div enable counter with registered tick (div 0 acts as 1).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tick_prescaler
    import tick_sched_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             clear,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    output logic             tick,
    output logic             at_term
);

    logic [DIV_W-1:0] count_q;
    logic [DIV_W-1:0] count_d;
    logic [DIV_W-1:0] term;
    logic             tick_q;
    logic             tick_d;

    assign term    = (div == '0) ? '0 : div - DIV_W'(1);
    assign at_term = (count_q == term);

    always_comb begin
        count_d = count_q;
        tick_d  = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            if (at_term) begin
                count_d = '0;
                tick_d  = 1'b1;
            end else begin
                count_d = count_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

`default_nettype wire

// File: rtl/tick_burst_sched.sv
//------------------------------------------------------------------------------
// tick_burst_sched: round-robin shared enable-tick prescaler issuing per-requester bursts.
// Optional TICK_BURST_SCHED_STATS_EN adds saturating stat_done/stat_abort counters. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tick_burst_sched
    import tick_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DIV_W = DEF_DIV_W,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DIV_W-1:0] req_div,
    input  logic [NREQ*LEN_W-1:0] req_len,
    output logic [NREQ-1:0]       gnt,
    output logic                  tick,
    output logic [LEN_W-1:0]      tick_num,
    output logic [NREQ-1:0]       done,
`ifdef TICK_BURST_SCHED_STATS_EN
    output logic [STAT_W-1:0]     stat_done,
    output logic [STAT_W-1:0]     stat_abort,
`endif
    output logic                  busy
);

    localparam int OW = $clog2(NREQ);

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [OW-1:0]     rr_q, rr_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  num_q, num_d;

    logic [DIV_W-1:0]  div_arr [NREQ];
    logic [LEN_W-1:0]  len_arr [NREQ];
    logic [OW-1:0]     win;
    logic              win_vld;
    logic [OW:0]       scan_sum;
    logic [OW-1:0]     scan_idx;
    logic [OW-1:0]     next_owner;
    logic              owner_req;
    logic              ps_clear;
    logic              ps_enable;
    logic              ps_tick;
    logic              ps_at_term;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign div_arr[g] = req_div[g*DIV_W +: DIV_W];
        assign len_arr[g] = req_len[g*LEN_W +: LEN_W];
    end

    // Round-robin scan: first asserted request at or above rr_q, wrapping modulo NREQ.
    always_comb begin
        win      = '0;
        win_vld  = 1'b0;
        scan_sum = '0;
        scan_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_sum = {1'b0, rr_q} + (OW+1)'(k);
            if (scan_sum >= (OW+1)'(NREQ)) begin
                scan_sum = scan_sum - (OW+1)'(NREQ);
            end
            scan_idx = scan_sum[OW-1:0];
            if (!win_vld && req[scan_idx]) begin
                win_vld = 1'b1;
                win     = scan_idx;
            end
        end
    end

    assign next_owner = (owner_q == OW'(NREQ-1)) ? '0 : owner_q + OW'(1);
    assign owner_req  = req[owner_q];
    assign ps_clear   = (state_q == ST_IDLE) && win_vld;
    // A dropped request gates the prescaler so a tick due on the abort edge never fires.
    assign ps_enable  = (state_q == ST_RUN) && owner_req;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        owner_d = owner_q;
        rr_d    = rr_q;
        div_d   = div_q;
        len_d   = len_q;
        num_d   = num_q;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    owner_d = win;
                    gnt_d   = NREQ'(1) << win;
                    div_d   = div_arr[win];
                    len_d   = len_arr[win];
                    num_d   = '0;
                    state_d = (len_arr[win] == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (!owner_req) begin
                    gnt_d   = '0;
                    rr_d    = next_owner;
                    state_d = ST_IDLE;
                end else if (ps_at_term) begin
                    num_d = num_q + LEN_W'(1);
                    if (num_d == len_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                gnt_d   = '0;
                done_d  = NREQ'(1) << owner_q;
                rr_d    = next_owner;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            owner_q <= '0;
            rr_q    <= '0;
            div_q   <= '0;
            len_q   <= '0;
            num_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            div_q   <= div_d;
            len_q   <= len_d;
            num_q   <= num_d;
        end
    end

    tick_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .clear   (ps_clear),
        .enable  (ps_enable),
        .div     (div_q),
        .tick    (ps_tick),
        .at_term (ps_at_term)
    );

`ifdef TICK_BURST_SCHED_STATS_EN
    logic              done_entry;
    logic              abort_evt;
    logic [STAT_W-1:0] stat_done_q;
    logic [STAT_W-1:0] stat_abort_q;

    assign done_entry = (state_d == ST_DONE) && (state_q != ST_DONE);
    assign abort_evt  = (state_q == ST_RUN) && !owner_req;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stat_done_q  <= '0;
            stat_abort_q <= '0;
        end else begin
            if (done_entry && (stat_done_q != '1)) begin
                stat_done_q <= stat_done_q + STAT_W'(1);
            end
            if (abort_evt && (stat_abort_q != '1)) begin
                stat_abort_q <= stat_abort_q + STAT_W'(1);
            end
        end
    end

    assign stat_done  = stat_done_q;
    assign stat_abort = stat_abort_q;
`endif

    assign gnt      = gnt_q;
    assign tick     = ps_tick;
    assign tick_num = num_q;
    assign done     = done_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_tick_burst_sched.sv
//------------------------------------------------------------------------------
// tb_tick_burst_sched: directed self-checking bench for tick_burst_sched.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_tick_burst_sched;

    localparam int NREQ  = 4;
    localparam int DIV_W = 3;
    localparam int LEN_W = 8;

    logic                  CLK = 1'b0;
    logic                  RST_N;
    logic [NREQ-1:0]       req;
    logic [NREQ*DIV_W-1:0] req_div;
    logic [NREQ*LEN_W-1:0] req_len;
    logic [NREQ-1:0]       gnt;
    logic                  tick;
    logic [LEN_W-1:0]      tick_num;
    logic [NREQ-1:0]       done;
    logic                  busy;
`ifdef TICK_BURST_SCHED_STATS_EN
    logic [15:0]           stat_done;
    logic [15:0]           stat_abort;
`endif

    int n_pass  = 0;
    int n_total = 0;

    logic [NREQ-1:0]  exp_gnt;
    logic [NREQ-1:0]  exp_done;
    logic             exp_tick;
    logic [LEN_W-1:0] exp_num;

    tick_burst_sched #(
        .NREQ  (NREQ),
        .DIV_W (DIV_W),
        .LEN_W (LEN_W)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .req        (req),
        .req_div    (req_div),
        .req_len    (req_len),
        .gnt        (gnt),
        .tick       (tick),
        .tick_num   (tick_num),
        .done       (done),
`ifdef TICK_BURST_SCHED_STATS_EN
        .stat_done  (stat_done),
        .stat_abort (stat_abort),
`endif
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_dut();
        req     = '0;
        req_div = '0;
        req_len = '0;
        RST_N   = 1'b1;
        #1 RST_N = 1'b0;
        step();
        step();
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        req     = '0;
        req_div = '0;
        req_len = '0;
        RST_N   = 1'b1;
        #2 RST_N = 1'b0;
        #1;
        n_total++;
        if (gnt !== 4'b0 || tick !== 1'b0 || tick_num !== 8'd0 || done !== 4'b0 || busy !== 1'b0) begin
            $display("FAIL reset_state got gnt=%b tick=%b num=%0d done=%b busy=%b want all zero",
                     gnt, tick, tick_num, done, busy);
        end else n_pass++;
        step();
        step();
        RST_N = 1'b1;
        step();
        n_total++;
        if (gnt !== 4'b0 || busy !== 1'b0) begin
            $display("FAIL reset_idle got gnt=%b busy=%b want 0000 0", gnt, busy);
        end else n_pass++;
    endtask

    task automatic test_single_burst();
        reset_dut();
        req_div = {3'd0, 3'd0, 3'd0, 3'd3};
        req_len = {8'd0, 8'd0, 8'd0, 8'd4};
        req     = 4'b0001;
        for (int e = 1; e <= 15; e++) begin
            step();
            exp_gnt  = (e <= 13) ? 4'b0001 : 4'b0000;
            exp_tick = (e == 4 || e == 7 || e == 10 || e == 13);
            exp_done = (e == 14) ? 4'b0001 : 4'b0000;
            exp_num  = (e >= 13) ? 8'd4 : (e >= 10) ? 8'd3 : (e >= 7) ? 8'd2 : (e >= 4) ? 8'd1 : 8'd0;
            n_total++;
            if (gnt !== exp_gnt || tick !== exp_tick || done !== exp_done || tick_num !== exp_num) begin
                $display("FAIL burst_edge%0d got gnt=%b tick=%b done=%b num=%0d want gnt=%b tick=%b done=%b num=%0d",
                         e, gnt, tick, done, tick_num, exp_gnt, exp_tick, exp_done, exp_num);
            end else n_pass++;
            if (e == 5 || e == 15) begin
                n_total++;
                if (busy !== (e == 5)) begin
                    $display("FAIL burst_busy_edge%0d got %b want %b", e, busy, (e == 5));
                end else n_pass++;
            end
            if (e == 13) req = 4'b0000;
        end
`ifdef TICK_BURST_SCHED_STATS_EN
        n_total++;
        if (stat_done !== 16'd1 || stat_abort !== 16'd0) begin
            $display("FAIL stat_after_burst got done=%0d abort=%0d want 1 0", stat_done, stat_abort);
        end else n_pass++;
`endif
    endtask

    task automatic test_round_robin();
        reset_dut();
        req_div = {3'd1, 3'd1, 3'd1, 3'd1};
        req_len = {8'd1, 8'd1, 8'd1, 8'd1};
        req     = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            exp_gnt = 4'b0001 << k;
            step();
            n_total++;
            if (gnt !== exp_gnt || tick !== 1'b0) begin
                $display("FAIL rr_grant%0d got gnt=%b tick=%b want gnt=%b tick=0", k, gnt, tick, exp_gnt);
            end else n_pass++;
            step();
            n_total++;
            if (gnt !== exp_gnt || tick !== 1'b1 || tick_num !== 8'd1) begin
                $display("FAIL rr_tick%0d got gnt=%b tick=%b num=%0d want gnt=%b tick=1 num=1",
                         k, gnt, tick, tick_num, exp_gnt);
            end else n_pass++;
            step();
            n_total++;
            if (gnt !== 4'b0000 || done !== exp_gnt || tick !== 1'b0) begin
                $display("FAIL rr_done%0d got gnt=%b done=%b tick=%b want gnt=0000 done=%b tick=0",
                         k, gnt, done, tick, exp_gnt);
            end else n_pass++;
            req[k] = 1'b0;
        end
        req = 4'b0001;
        step();
        n_total++;
        if (gnt !== 4'b0001 || tick !== 1'b0 || tick_num !== 8'd0) begin
            $display("FAIL rr_wrap_grant got gnt=%b tick=%b num=%0d want 0001 0 0", gnt, tick, tick_num);
        end else n_pass++;
        step();
        n_total++;
        if (gnt !== 4'b0001 || tick !== 1'b1) begin
            $display("FAIL rr_wrap_tick got gnt=%b tick=%b want 0001 1", gnt, tick);
        end else n_pass++;
        req = 4'b0000;
        step();
        step();
    endtask

    task automatic test_div_zero();
        reset_dut();
        req_div = {3'd0, 3'd0, 3'd0, 3'd0};
        req_len = {8'd0, 8'd3, 8'd0, 8'd0};
        req     = 4'b0100;
        for (int e = 1; e <= 6; e++) begin
            step();
            exp_gnt  = (e <= 4) ? 4'b0100 : 4'b0000;
            exp_tick = (e >= 2 && e <= 4);
            exp_done = (e == 5) ? 4'b0100 : 4'b0000;
            exp_num  = (e >= 4) ? 8'd3 : (e == 3) ? 8'd2 : (e == 2) ? 8'd1 : 8'd0;
            n_total++;
            if (gnt !== exp_gnt || tick !== exp_tick || done !== exp_done || tick_num !== exp_num) begin
                $display("FAIL div0_edge%0d got gnt=%b tick=%b done=%b num=%0d want gnt=%b tick=%b done=%b num=%0d",
                         e, gnt, tick, done, tick_num, exp_gnt, exp_tick, exp_done, exp_num);
            end else n_pass++;
            if (e == 4) req = 4'b0000;
        end
    endtask

    task automatic test_len_zero();
        reset_dut();
        req_div = {3'd2, 3'd2, 3'd2, 3'd2};
        req_len = {8'd5, 8'd5, 8'd0, 8'd5};
        req     = 4'b0010;
        for (int e = 1; e <= 3; e++) begin
            step();
            exp_gnt  = (e == 1) ? 4'b0010 : 4'b0000;
            exp_done = (e == 2) ? 4'b0010 : 4'b0000;
            n_total++;
            if (gnt !== exp_gnt || tick !== 1'b0 || done !== exp_done || tick_num !== 8'd0) begin
                $display("FAIL len0_edge%0d got gnt=%b tick=%b done=%b num=%0d want gnt=%b tick=0 done=%b num=0",
                         e, gnt, tick, done, tick_num, exp_gnt, exp_done);
            end else n_pass++;
            if (e == 1) req = 4'b0000;
        end
    endtask

    task automatic test_abort();
        reset_dut();
        req_div = {3'd0, 3'd0, 3'd2, 3'd0};
        req_len = {8'd0, 8'd0, 8'd5, 8'd0};
        req     = 4'b0010;
        for (int e = 1; e <= 10; e++) begin
            step();
            exp_gnt  = (e <= 6) ? 4'b0010 : 4'b0000;
            exp_tick = (e == 3 || e == 5);
            exp_num  = (e >= 5) ? 8'd2 : (e >= 3) ? 8'd1 : 8'd0;
            n_total++;
            if (gnt !== exp_gnt || tick !== exp_tick || done !== 4'b0000 || tick_num !== exp_num) begin
                $display("FAIL abort_edge%0d got gnt=%b tick=%b done=%b num=%0d want gnt=%b tick=%b done=0000 num=%0d",
                         e, gnt, tick, done, tick_num, exp_gnt, exp_tick, exp_num);
            end else n_pass++;
            if (e == 6) req = 4'b0000;
        end
`ifdef TICK_BURST_SCHED_STATS_EN
        n_total++;
        if (stat_abort !== 16'd1 || stat_done !== 16'd0) begin
            $display("FAIL stat_after_abort got abort=%0d done=%0d want 1 0", stat_abort, stat_done);
        end else n_pass++;
`endif
    endtask

    task automatic test_async_reset();
        reset_dut();
        req_div = {3'd0, 3'd0, 3'd0, 3'd0};
        req_len = {8'd8, 8'd8, 8'd8, 8'd1};
        req     = 4'b0001;
        step();
        step();
        step();
        req = 4'b0010;
        step();
        step();
        step();
        n_total++;
        if (gnt !== 4'b0010 || tick !== 1'b1 || tick_num !== 8'd2) begin
            $display("FAIL pre_reset got gnt=%b tick=%b num=%0d want 0010 1 2", gnt, tick, tick_num);
        end else n_pass++;
        #2 RST_N = 1'b0;
        #1;
        n_total++;
        if (gnt !== 4'b0 || tick !== 1'b0 || tick_num !== 8'd0 || done !== 4'b0 || busy !== 1'b0) begin
            $display("FAIL async_reset got gnt=%b tick=%b num=%0d done=%b busy=%b want all zero",
                     gnt, tick, tick_num, done, busy);
        end else n_pass++;
        req = 4'b1001;
        step();
        step();
        RST_N = 1'b1;
        step();
        n_total++;
        if (gnt !== 4'b0001 || busy !== 1'b1) begin
            $display("FAIL post_reset_prio got gnt=%b busy=%b want 0001 1", gnt, busy);
        end else n_pass++;
        req = 4'b0000;
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_div_zero();
        test_len_zero();
        test_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
